// File: rtl/mem_2rw_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_2rw_arb_pkg;

  localparam int unsigned MAX_LATENCY = 30;
  localparam int unsigned MAX_NREQ    = 8;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ID_W = id_width(MAX_NREQ);

  // One slot of the read-return tag pipeline.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } inflight_t;

endpackage

// File: rtl/mem_2rw_arb_pick2.sv
// Two-winner rotating-priority picker with same-address hazard check on the
// second winner. Purely combinational.
module rr_pick2 #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0]    i_elig,
  input  logic [NREQ-1:0]    i_wr,
  input  logic [IDW-1:0]     i_ptr,
  input  logic [NREQ*AW-1:0] i_addr,
  output logic               o_g0_vld,
  output logic [IDW-1:0]     o_g0_idx,
  output logic               o_g1_vld,
  output logic [IDW-1:0]     o_g1_idx
);

  int unsigned    w_idx;
  logic [IDW-1:0] w_sel;
  logic           w_stop;

  // Scan from ptr; the first eligible is g0, the next one ends the scan and
  // becomes g1 only if it does not conflict with g0's address.
  always_comb begin
    o_g0_vld = 1'b0;
    o_g0_idx = '0;
    o_g1_vld = 1'b0;
    o_g1_idx = '0;
    w_idx    = 0;
    w_sel    = '0;
    w_stop   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(i_ptr) + k) % NREQ;
      w_sel = IDW'(w_idx);
      if (i_elig[w_sel] && !w_stop) begin
        if (!o_g0_vld) begin
          o_g0_vld = 1'b1;
          o_g0_idx = w_sel;
        end else begin
          w_stop = 1'b1;
          if (!((i_addr[32'(w_sel)*AW +: AW] == i_addr[32'(o_g0_idx)*AW +: AW]) &&
                (i_wr[w_sel] || i_wr[o_g0_idx]))) begin
            o_g1_vld = 1'b1;
            o_g1_idx = w_sel;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_2rw_arb.sv
// Round-robin arbiter sharing a two-port read/write memory among NREQ
// requesters, with per-port read tag pipelines routing data back.
module mem_2rw_arb
  import mem_2rw_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 32,
  parameter int unsigned WORDS   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_din,
  input  logic [NREQ*DW-1:0] req_bw,
  output logic [NREQ-1:0]    req_rdy,
  output logic [NREQ-1:0]    rsp_vld,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic [NREQ-1:0]    rsp_serr,
  output logic [NREQ-1:0]    rsp_derr,
  output logic [NREQ-1:0]    err_oor,
  output logic               read_0,
  output logic               write_0,
  output logic               read_1,
  output logic               write_1,
  output logic [AW-1:0]      addr_0,
  output logic [AW-1:0]      addr_1,
  output logic [DW-1:0]      din_0,
  output logic [DW-1:0]      din_1,
  output logic [DW-1:0]      bw_0,
  output logic [DW-1:0]      bw_1,
  input  logic [DW-1:0]      dout_0,
  input  logic [DW-1:0]      dout_1,
  input  logic               read_serr_0,
  input  logic               read_serr_1,
  input  logic               read_derr_0,
  input  logic               read_derr_1
);

  localparam int unsigned IDW = id_width(NREQ);

  if (LATENCY < 1 || LATENCY >= MAX_LATENCY) begin : g_bad_latency
    $error("mem_2rw_arb: LATENCY must be 1..%0d", MAX_LATENCY - 1);
  end
  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("mem_2rw_arb: NREQ must be 2..%0d", MAX_NREQ);
  end

  logic [IDW-1:0]  r_ptr;
  inflight_t       r_p0 [LATENCY];
  inflight_t       r_p1 [LATENCY];

  logic [NREQ-1:0] w_oor;
  logic [NREQ-1:0] w_elig;
  logic            w_g0_vld, w_g1_vld;
  logic [IDW-1:0]  w_g0_idx, w_g1_idx;
  logic            w_on0, w_on1;
  logic [NREQ-1:0] w_hit0, w_hit1;

  // Out-of-range requests are consumed here and never reach the picker.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign w_oor[i]  = req_vld[i] && (64'(req_addr[i*AW +: AW]) >= 64'(WORDS));
    assign w_elig[i] = req_vld[i] && !w_oor[i];
    assign req_rdy[i] = !rst && (w_oor[i] ||
                                 (w_g0_vld && (w_g0_idx == IDW'(i))) ||
                                 (w_g1_vld && (w_g1_idx == IDW'(i))));
    assign err_oor[i] = !rst && w_oor[i];

    assign w_hit0[i] = !rst && r_p0[LATENCY-1].vld && (r_p0[LATENCY-1].id == ID_W'(i));
    assign w_hit1[i] = !rst && r_p1[LATENCY-1].vld && (r_p1[LATENCY-1].id == ID_W'(i));
    assign rsp_vld[i] = w_hit0[i] || w_hit1[i];
    assign rsp_data[i*DW +: DW] = w_hit0[i] ? dout_0 : (w_hit1[i] ? dout_1 : '0);
    assign rsp_serr[i] = (w_hit0[i] && read_serr_0) || (w_hit1[i] && read_serr_1);
    assign rsp_derr[i] = (w_hit0[i] && read_derr_0) || (w_hit1[i] && read_derr_1);
  end

  rr_pick2 #(
    .NREQ (NREQ),
    .AW   (AW),
    .IDW  (IDW)
  ) u_pick (
    .i_elig   (w_elig),
    .i_wr     (req_wr),
    .i_ptr    (r_ptr),
    .i_addr   (req_addr),
    .o_g0_vld (w_g0_vld),
    .o_g0_idx (w_g0_idx),
    .o_g1_vld (w_g1_vld),
    .o_g1_idx (w_g1_idx)
  );

  assign w_on0   = !rst && w_g0_vld;
  assign w_on1   = !rst && w_g1_vld;
  assign read_0  = w_on0 && !req_wr[w_g0_idx];
  assign write_0 = w_on0 &&  req_wr[w_g0_idx];
  assign read_1  = w_on1 && !req_wr[w_g1_idx];
  assign write_1 = w_on1 &&  req_wr[w_g1_idx];
  assign addr_0  = w_on0 ? req_addr[32'(w_g0_idx)*AW +: AW] : '0;
  assign addr_1  = w_on1 ? req_addr[32'(w_g1_idx)*AW +: AW] : '0;
  assign din_0   = w_on0 ? req_din[32'(w_g0_idx)*DW +: DW] : '0;
  assign din_1   = w_on1 ? req_din[32'(w_g1_idx)*DW +: DW] : '0;
  assign bw_0    = w_on0 ? req_bw[32'(w_g0_idx)*DW +: DW] : '0;
  assign bw_1    = w_on1 ? req_bw[32'(w_g1_idx)*DW +: DW] : '0;

  // Advance the round-robin pointer past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_g1_vld) begin
      r_ptr <= (32'(w_g1_idx) == NREQ - 1) ? '0 : w_g1_idx + IDW'(1);
    end else if (w_g0_vld) begin
      r_ptr <= (32'(w_g0_idx) == NREQ - 1) ? '0 : w_g0_idx + IDW'(1);
    end
  end

  // Tag pipelines: the last stage lines up with the memory's read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        r_p0[s] <= '0;
        r_p1[s] <= '0;
      end
    end else begin
      r_p0[0].vld <= read_0;
      r_p0[0].id  <= ID_W'(w_g0_idx);
      r_p1[0].vld <= read_1;
      r_p1[0].id  <= ID_W'(w_g1_idx);
      for (int unsigned s = 1; s < LATENCY; s++) begin
        r_p0[s] <= r_p0[s-1];
        r_p1[s] <= r_p1[s-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_2rw_arb.sv
// Self-checking bench for mem_2rw_arb: vector table for grants/port driving,
// scoreboard queue for read returns, plus a mid-operation reset sequence.
module tb_mem_2rw_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 1024;
  localparam int unsigned L     = 2;

  localparam logic [1:0] NO = 2'd0;
  localparam logic [1:0] RD = 2'd1;
  localparam logic [1:0] WR = 2'd2;

  typedef struct packed {
    logic [NREQ-1:0]          vld;
    logic [NREQ-1:0]          wr;
    logic [NREQ-1:0][AW-1:0]  a;
    logic [NREQ-1:0][DW-1:0]  din;
    logic [NREQ-1:0][DW-1:0]  bw;
    logic                     inj_s0;
    logic                     inj_d1;
    logic [NREQ-1:0]          e_rdy;
    logic [NREQ-1:0]          e_oor;
    logic [1:0]               e_p0;
    logic [1:0]               e_id0;
    logic [1:0]               e_p1;
    logic [1:0]               e_id1;
  } vec_t;

  typedef struct packed {
    int unsigned  due;
    logic [1:0]   id;
    logic [DW-1:0] data;
    logic         serr;
    logic         derr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_vld, req_wr, req_rdy, rsp_vld, rsp_serr, rsp_derr, err_oor;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_din, req_bw, rsp_data;
  logic read_0, write_0, read_1, write_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] din_0, din_1, bw_0, bw_1, dout_0, dout_1;
  logic read_serr_0, read_serr_1, read_derr_0, read_derr_1;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;
  logic        inj_s0 = 1'b0;
  logic        inj_d1 = 1'b0;

  logic [DW-1:0] mem     [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic [L-1:0][DW-1:0] pd0, pd1;
  logic [L-1:0] ps0, ps1, pe0, pe1;

  exp_t sbq[$];
  exp_t m_keep[$];
  logic [NREQ-1:0] m_ev, m_es, m_ed;
  logic [NREQ-1:0][DW-1:0] m_dat;

  vec_t tv [16];
  vec_t idle;

  mem_2rw_arb #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .WORDS   (WORDS),
    .LATENCY (L)
  ) dut (
    .clk (clk), .rst (rst),
    .req_vld (req_vld), .req_wr (req_wr), .req_addr (req_addr),
    .req_din (req_din), .req_bw (req_bw), .req_rdy (req_rdy),
    .rsp_vld (rsp_vld), .rsp_data (rsp_data), .rsp_serr (rsp_serr),
    .rsp_derr (rsp_derr), .err_oor (err_oor),
    .read_0 (read_0), .write_0 (write_0), .read_1 (read_1), .write_1 (write_1),
    .addr_0 (addr_0), .addr_1 (addr_1), .din_0 (din_0), .din_1 (din_1),
    .bw_0 (bw_0), .bw_1 (bw_1), .dout_0 (dout_0), .dout_1 (dout_1),
    .read_serr_0 (read_serr_0), .read_serr_1 (read_serr_1),
    .read_derr_0 (read_derr_0), .read_derr_1 (read_derr_1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural two-port memory with L-cycle read latency and ECC injection.
  always @(posedge clk) begin
    if (write_0 && addr_0 < WORDS) mem[addr_0] <= (mem[addr_0] & ~bw_0) | (din_0 & bw_0);
    if (write_1 && addr_1 < WORDS) mem[addr_1] <= (mem[addr_1] & ~bw_1) | (din_1 & bw_1);
    for (int s = L - 1; s > 0; s--) begin
      pd0[s] <= pd0[s-1]; pd1[s] <= pd1[s-1];
      ps0[s] <= ps0[s-1]; ps1[s] <= ps1[s-1];
      pe0[s] <= pe0[s-1]; pe1[s] <= pe1[s-1];
    end
    pd0[0] <= (read_0 && addr_0 < WORDS) ? mem[addr_0] : '0;
    pd1[0] <= (read_1 && addr_1 < WORDS) ? mem[addr_1] : '0;
    ps0[0] <= read_0 && inj_s0;
    ps1[0] <= 1'b0;
    pe0[0] <= 1'b0;
    pe1[0] <= read_1 && inj_d1;
  end

  assign dout_0      = pd0[L-1];
  assign dout_1      = pd1[L-1];
  assign read_serr_0 = ps0[L-1];
  assign read_serr_1 = ps1[L-1];
  assign read_derr_0 = pe0[L-1];
  assign read_derr_1 = pe1[L-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: pop every entry due this cycle and compare the response lanes.
  always @(negedge clk) begin
    if (mon_en) begin
      m_ev = '0; m_es = '0; m_ed = '0; m_dat = '0;
      m_keep = {};
      foreach (sbq[j]) begin
        if (sbq[j].due == cyc) begin
          m_ev[sbq[j].id]  = 1'b1;
          m_es[sbq[j].id]  = sbq[j].serr;
          m_ed[sbq[j].id]  = sbq[j].derr;
          m_dat[sbq[j].id] = sbq[j].data;
        end else begin
          m_keep.push_back(sbq[j]);
        end
      end
      sbq = m_keep;
      check("rsp_vld", 64'(rsp_vld), 64'(m_ev));
      for (int i = 0; i < int'(NREQ); i++) begin
        if (m_ev[i]) begin
          check($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*DW +: DW]), 64'(m_dat[i]));
          check($sformatf("rsp_serr[%0d]", i), 64'(rsp_serr[i]), 64'(m_es[i]));
          check($sformatf("rsp_derr[%0d]", i), 64'(rsp_derr[i]), 64'(m_ed[i]));
        end
      end
    end
  end

  function automatic vec_t mkv(input logic [3:0] vld, input logic [3:0] wr,
                               input int a0, input int a1, input int a2, input int a3,
                               input logic [3:0] rdy, input logic [3:0] oor,
                               input logic [1:0] p0, input logic [1:0] id0,
                               input logic [1:0] p1, input logic [1:0] id1);
    vec_t v;
    v = '0;
    v.vld = vld; v.wr = wr;
    v.a[0] = AW'(a0); v.a[1] = AW'(a1); v.a[2] = AW'(a2); v.a[3] = AW'(a3);
    v.e_rdy = rdy; v.e_oor = oor;
    v.e_p0 = p0; v.e_id0 = id0; v.e_p1 = p1; v.e_id1 = id1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_vld  = v.vld;
    req_wr   = v.wr;
    req_addr = v.a;
    req_din  = v.din;
    req_bw   = v.bw;
    inj_s0   = v.inj_s0;
    inj_d1   = v.inj_d1;
  endtask

  task automatic apply(input vec_t v, input bit push_rsp);
    logic [AW-1:0] a0, a1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(v);
    @(negedge clk);
    a0 = (v.e_p0 != NO) ? v.a[v.e_id0] : '0;
    a1 = (v.e_p1 != NO) ? v.a[v.e_id1] : '0;
    check("req_rdy", 64'(req_rdy), 64'(v.e_rdy));
    check("err_oor", 64'(err_oor), 64'(v.e_oor));
    check("read_0",  64'(read_0),  64'(v.e_p0 == RD));
    check("write_0", 64'(write_0), 64'(v.e_p0 == WR));
    check("addr_0",  64'(addr_0),  64'(a0));
    check("read_1",  64'(read_1),  64'(v.e_p1 == RD));
    check("write_1", 64'(write_1), 64'(v.e_p1 == WR));
    check("addr_1",  64'(addr_1),  64'(a1));
    if (v.e_p0 == WR) begin
      check("din_0", 64'(din_0), 64'(v.din[v.e_id0]));
      check("bw_0",  64'(bw_0),  64'(v.bw[v.e_id0]));
    end
    if (push_rsp && v.e_p0 == RD)
      sbq.push_back('{due: cyc + L, id: v.e_id0, data: ref_mem[a0], serr: v.inj_s0, derr: 1'b0});
    if (push_rsp && v.e_p1 == RD)
      sbq.push_back('{due: cyc + L, id: v.e_id1, data: ref_mem[a1], serr: 1'b0, derr: v.inj_d1});
    if (v.e_p0 == WR)
      ref_mem[a0] = (ref_mem[a0] & ~v.bw[v.e_id0]) | (v.din[v.e_id0] & v.bw[v.e_id0]);
    if (v.e_p1 == WR)
      ref_mem[a1] = (ref_mem[a1] & ~v.bw[v.e_id1]) | (v.din[v.e_id1] & v.bw[v.e_id1]);
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      mem[i]     <= '0;
      ref_mem[i]  = '0;
    end
    for (int i = 10; i < 14; i++) begin
      mem[i]     <= 32'h0000_1000 + 32'(i);
      ref_mem[i]  = 32'h0000_1000 + 32'(i);
    end
    mem[5]  <= 32'hDEAD_BEEF; ref_mem[5]  = 32'hDEAD_BEEF;
    mem[7]  <= 32'h1111_1111; ref_mem[7]  = 32'h1111_1111;
    mem[20] <= 32'hAAAA_AAAA; ref_mem[20] = 32'hAAAA_AAAA;
    mem[31] <= 32'h3131_3131; ref_mem[31] = 32'h3131_3131;

    idle   = mkv(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, NO, 0, NO, 0);
    tv[0]  = mkv(4'b1111, 4'b0000, 10, 11, 12, 13, 4'b0011, 4'b0000, RD, 0, RD, 1);
    tv[1]  = mkv(4'b1100, 4'b0000, 10, 11, 12, 13, 4'b1100, 4'b0000, RD, 2, RD, 3);
    tv[2]  = mkv(4'b0010, 4'b0000, 0, 5, 0, 0,     4'b0010, 4'b0000, RD, 1, NO, 0);
    tv[3]  = mkv(4'b0011, 4'b0001, 7, 7, 0, 0,     4'b0001, 4'b0000, WR, 0, NO, 0);
    tv[3].din[0] = 32'hCAFE_F00D; tv[3].bw[0] = '1;
    tv[4]  = mkv(4'b0010, 4'b0000, 0, 7, 0, 0,     4'b0010, 4'b0000, RD, 1, NO, 0);
    tv[5]  = mkv(4'b0100, 4'b0000, 0, 0, 1024, 0,  4'b0100, 4'b0100, NO, 0, NO, 0);
    tv[6]  = mkv(4'b0101, 4'b0000, 10, 0, 1500, 0, 4'b0101, 4'b0100, RD, 0, NO, 0);
    tv[7]  = mkv(4'b1010, 4'b1000, 0, 20, 0, 20,   4'b0010, 4'b0000, RD, 1, NO, 0);
    tv[7].din[3] = 32'h1234_5678; tv[7].bw[3] = 32'h0000_FFFF;
    tv[8]  = mkv(4'b1000, 4'b1000, 0, 0, 0, 20,    4'b1000, 4'b0000, WR, 3, NO, 0);
    tv[8].din[3] = 32'h1234_5678; tv[8].bw[3] = 32'h0000_FFFF;
    tv[9]  = mkv(4'b0101, 4'b0000, 20, 0, 20, 0,   4'b0101, 4'b0000, RD, 0, RD, 2);
    tv[9].inj_s0 = 1'b1; tv[9].inj_d1 = 1'b1;
    tv[10] = idle;
    tv[11] = mkv(4'b1111, 4'b0000, 10, 11, 12, 13, 4'b1001, 4'b0000, RD, 3, RD, 0);
    tv[12] = mkv(4'b0110, 4'b0000, 0, 11, 12, 0,   4'b0110, 4'b0000, RD, 1, RD, 2);
    tv[13] = mkv(4'b1001, 4'b1001, 30, 0, 0, 30,   4'b1000, 4'b0000, WR, 3, NO, 0);
    tv[13].din[0] = 32'h2; tv[13].bw[0] = '1; tv[13].din[3] = 32'h1; tv[13].bw[3] = '1;
    tv[14] = mkv(4'b0011, 4'b0001, 30, 31, 0, 0,   4'b0011, 4'b0000, WR, 0, RD, 1);
    tv[14].din[0] = 32'h2; tv[14].bw[0] = '1;
    tv[15] = mkv(4'b0001, 4'b0000, 30, 0, 0, 0,    4'b0001, 4'b0000, RD, 0, NO, 0);

    // Initial reset with live requests: everything must stay quiet.
    rst = 1'b1;
    drive(tv[0]);
    @(negedge clk);
    check("rst_rdy",   64'(req_rdy), 64'(0));
    check("rst_read0", 64'(read_0),  64'(0));
    check("rst_read1", 64'(read_1),  64'(0));
    check("rst_addr0", 64'(addr_0),  64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    drive(idle);
    mon_en = 1'b1;

    foreach (tv[k]) apply(tv[k], 1'b1);
    repeat (3) apply(idle, 1'b1);

    // Mid-operation reset: reads in flight are dropped and ptr returns to 0.
    apply(mkv(4'b1000, 4'b0000, 0, 0, 0, 13, 4'b1000, 4'b0000, RD, 3, NO, 0), 1'b0);
    apply(mkv(4'b0100, 4'b0000, 0, 0, 5, 0,  4'b0100, 4'b0000, RD, 2, NO, 0), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(mkv(4'b1111, 4'b0001, 10, 11, 1500, 13, 4'b0000, 4'b0000, NO, 0, NO, 0));
    @(negedge clk);
    check("mid_rst_rdy",    64'(req_rdy),  64'(0));
    check("mid_rst_oor",    64'(err_oor),  64'(0));
    check("mid_rst_strobe", 64'({read_0, write_0, read_1, write_1}), 64'(0));
    check("mid_rst_addr",   64'({addr_0, addr_1}), 64'(0));
    check("mid_rst_din",    64'({din_0, din_1}),   64'(0));
    check("mid_rst_bw",     64'({bw_0, bw_1}),     64'(0));
    check("mid_rst_rsp",    64'({rsp_vld, rsp_serr, rsp_derr}), 64'(0));
    check("mid_rst_data",   64'(rsp_data[63:0]), 64'(0));
    apply(tv[0], 1'b1);
    repeat (4) apply(idle, 1'b1);

    check("sb_empty", 64'(sbq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_2rw_arb.md
# mem_2rw_arb

Round-robin arbiter and read-return sequencer that shares one two-port read/write memory (the `mem_beh_2rw` port set) among NREQ requesters. Each cycle it grants up to two requests, drives them onto memory ports 0 and 1, tracks in-flight reads through a LATENCY-deep tag pipeline and routes returned data and ECC flags back to the issuing requester. It sits between client logic and the memory macro or behavioural model, and guarantees the macro's legality rules: no read+write on one port, no out-of-range address, no same-address conflict.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 10, address width
- DW, 32, data / bit-enable width
- WORDS, 1024, memory depth; addresses >= WORDS are illegal
- LATENCY, 2, memory read latency in cycles (1..29; 0 rejected at elaboration)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_vld  in  NREQ  request valid per requester
- req_wr  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  per-requester address, slice i = [i*AW +: AW]
- req_din  in  NREQ*DW  write data
- req_bw  in  NREQ*DW  write bit enables
- req_rdy  out  NREQ  grant; transfer occurs when req_vld & req_rdy
- rsp_vld  out  NREQ  read data valid, one-cycle pulse
- rsp_data  out  NREQ*DW  read data, meaningful only with rsp_vld
- rsp_serr, rsp_derr  out  NREQ  ECC flags qualified by rsp_vld
- err_oor  out  NREQ  pulse: request dropped, address >= WORDS
- read_0, write_0, read_1, write_1  out  1  memory port strobes
- addr_0, addr_1  out  AW;  din_0, din_1, bw_0, bw_1  out  DW
- dout_0, dout_1  in  DW;  read_serr_0/1, read_derr_0/1  in  1

## Operation
- Round-robin pointer ptr (log2 NREQ bits), reset to 0.
- Candidate set: requesters with req_vld=1. Out-of-range candidates (addr >= WORDS) are consumed immediately: req_rdy=1, err_oor=1, nothing issued, no response. They do not take a port and do not move ptr.
- First grant g0 = first in-range candidate scanning ptr, ptr+1, … mod NREQ; issued on port 0.
- Second grant g1 = next in-range candidate after g0 in the same scan; issued on port 1 unless hazard: addr equal to g0's and either is a write. Hazarded g1 is not granted and the scan does not continue past it; it retries next cycle.
- Read-read to the same address on both ports is legal and granted.
- Port driving: read_p = granted & ~wr, write_p = granted & wr; addr/din/bw from granted requester; all port outputs 0 when no grant on that port.
- ptr update: (last granted index + 1) mod NREQ; unchanged if no grant.
- Read tracking: per port, shift register of {vld, id} depth LATENCY loaded at grant. At stage LATENCY-1 output, rsp_vld[id]=1, rsp_data slice id = dout_p, ECC flags from read_serr_p/derr_p. Both ports may return to different requesters in the same cycle. The same requester cannot be granted twice in one cycle, so ports never collide on one id.
- Writes: fire-and-forget, no response.

## Timing
- req_rdy, err_oor and port outputs are combinational from req_* and ptr; ptr and tag pipeline are registered.
- Read granted in cycle T: rsp_vld asserted in cycle T+LATENCY, combinational from dout.
- Back-to-back: one requester may be granted every cycle; full throughput is 2 grants/cycle.
- Reset, including mid-operation: while rst=1 all outputs are 0 (req_rdy, strobes, rsp_vld, rsp_*, err_oor, addr/din/bw). ptr=0 and tag pipelines are cleared, so in-flight reads return no response. First grants are possible in the first cycle after rst deasserts.

## Structure
- Package mem_2rw_arb_pkg: inflight_t struct {logic vld; logic [IDW-1:0] id;}, function clog2-based IDW, MAX_LATENCY=30 constant.
- Sub-module rr_pick2: combinational two-winner rotating priority picker (inputs: eligible mask, ptr, hazard-check addr/wr; outputs: g0/g1 valid+index). Top holds ptr, OOR filter, port muxes and two inflight_t pipelines.

## Test plan
- Single read: R1 reads addr 5 (pre-written 0xDEADBEEF), LATENCY=2 -> port 0 read at T, rsp_vld[1]=1 with 0xDEADBEEF at T+2.
- All four read, ptr=0 -> cycle 0 grants R0 (p0), R1 (p1); cycle 1 grants R2, R3; ptr ends at 0; four responses in order.
- R0 write addr 7, R1 read addr 7 same cycle -> only R0 granted; R1 granted next cycle and returns the new data.
- R2 reads addr 1024 -> req_rdy[2]=1, err_oor[2]=1, no memory strobe, no rsp_vld.
- Reads in flight, rst pulsed 1 cycle -> no rsp_vld afterwards, ptr=0, all outputs 0 during reset.
- Write with bw=0x0000FFFF, din=0x12345678 over 0xAAAAAAAA -> read back 0xAAAA5678; read_serr_0 forced -> rsp_serr on the matching requester only.
